// File: rtl/rca8_share_ctrl_pkg.sv
// Shared definitions for the byte-serial shared-adder controller:
// FSM state encoding, requester IDs, legal width range and the round-robin pick.
package rca8_share_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic ID_R0 = 1'b0;
  localparam logic ID_R1 = 1'b1;

  localparam int NBYTES_MIN = 1;
  localparam int NBYTES_MAX = 4;

  // Sole valid requester wins; on a tie the one that was not granted last wins.
  function automatic logic rr_pick(input logic v0, input logic v1, input logic last);
    if (v0 && v1) return ~last;
    return v0 ? ID_R0 : ID_R1;
  endfunction

endpackage

// File: rtl/rca8_ci.sv
// 8-bit ripple-carry adder with carry-in; one full adder per bit position.
module rca8_ci (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       ci,
  output logic [7:0] s,
  output logic       co
);

  logic [8:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < 8; i++) begin : g_fa
    assign s[i]     = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign co = c[8];

endmodule

// File: rtl/rca8_share_ctrl.sv
// Two requesters share one 8-bit adder; NBYTES-wide add/sub runs LSB byte first
// with the carry chained through a register, result returned with requester ID.
module rca8_share_ctrl
  import rca8_share_ctrl_pkg::*;
#(
  parameter  int NBYTES = 2,
  localparam int W      = 8 * NBYTES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         r0_valid,
  output logic         r0_ready,
  input  logic         r0_sub,
  input  logic [W-1:0] r0_a,
  input  logic [W-1:0] r0_b,
  input  logic         r1_valid,
  output logic         r1_ready,
  input  logic         r1_sub,
  input  logic [W-1:0] r1_a,
  input  logic [W-1:0] r1_b,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [W-1:0] rsp_sum,
  output logic         rsp_c,
  output logic         rsp_v,
  output logic         rsp_z
);

  if (NBYTES < NBYTES_MIN || NBYTES > NBYTES_MAX) begin : g_bad_nbytes
    $error("rca8_share_ctrl: NBYTES must be in 1..4");
  end

  state_t       state, state_next;
  logic         accept, winner, last_byte, last_grant;
  logic         sel_sub;
  logic [W-1:0] sel_a, sel_b, sum_next;
  logic [W-1:0] a_q, b_q, sum_q;
  logic         carry_q, id_q, a_msb_q, b_msb_q;
  logic         c_q, v_q, z_q;
  logic [2:0]   k_q;
  logic [7:0]   byte_s;
  logic         byte_co;

  rca8_ci u_adder (
    .a  (a_q[7:0]),
    .b  (b_q[7:0]),
    .ci (carry_q),
    .s  (byte_s),
    .co (byte_co)
  );

  assign winner    = rr_pick(r0_valid, r1_valid, last_grant);
  assign sel_sub   = (winner == ID_R1) ? r1_sub : r0_sub;
  assign sel_a     = (winner == ID_R1) ? r1_a   : r0_a;
  assign sel_b     = ((winner == ID_R1) ? r1_b : r0_b) ^ {W{sel_sub}};
  assign last_byte = (k_q == 3'(NBYTES - 1));
  // New byte enters at the top; after NBYTES shifts byte 0 sits at the bottom.
  assign sum_next  = W'({byte_s, sum_q} >> 8);

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // NOTE: every output of this block gets a default first so no path infers a latch.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    r0_ready   = 1'b0;
    r1_ready   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!rst && (r0_valid || r1_valid)) begin
          accept     = 1'b1;
          r0_ready   = (winner == ID_R0);
          r1_ready   = (winner == ID_R1);
          state_next = ST_RUN;
        end
      end
      ST_RUN:  if (last_byte) state_next = ST_DONE;
      ST_DONE: if (rsp_ready) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // NOTE: datapath registers are reset too (no RAM here) so the response
  // fields read zero out of reset rather than X.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q        <= '0;
      b_q        <= '0;
      sum_q      <= '0;
      carry_q    <= 1'b0;
      id_q       <= ID_R0;
      a_msb_q    <= 1'b0;
      b_msb_q    <= 1'b0;
      k_q        <= '0;
      c_q        <= 1'b0;
      v_q        <= 1'b0;
      z_q        <= 1'b0;
      last_grant <= ID_R1;
    end else if (accept) begin
      a_q        <= sel_a;
      b_q        <= sel_b;
      carry_q    <= sel_sub;
      id_q       <= winner;
      a_msb_q    <= sel_a[W-1];
      b_msb_q    <= sel_b[W-1];
      k_q        <= '0;
      last_grant <= winner;
    end else if (state == ST_RUN) begin
      a_q     <= a_q >> 8;
      b_q     <= b_q >> 8;
      sum_q   <= sum_next;
      carry_q <= byte_co;
      k_q     <= k_q + 3'd1;
      if (last_byte) begin
        c_q <= byte_co;
        v_q <= (a_msb_q == b_msb_q) && (byte_s[7] != a_msb_q);
        z_q <= ~|sum_next;
      end
    end
  end

  assign rsp_valid = (state == ST_DONE);
  assign rsp_id    = id_q;
  assign rsp_sum   = sum_q;
  assign rsp_c     = c_q;
  assign rsp_v     = v_q;
  assign rsp_z     = z_q;

endmodule

// File: tb/tb_rca8_share_ctrl.sv
// Self-checking bench for rca8_share_ctrl: directed vector table, arbitration,
// backpressure and reset corner cases, then randomized traffic against a model.
module tb_rca8_share_ctrl;

  localparam int NBYTES = 2;
  localparam int W      = 8 * NBYTES;

  logic         clk = 1'b0;
  logic         rst;
  logic         r0_valid, r0_ready, r0_sub;
  logic [W-1:0] r0_a, r0_b;
  logic         r1_valid, r1_ready, r1_sub;
  logic [W-1:0] r1_a, r1_b;
  logic         rsp_valid, rsp_ready, rsp_id;
  logic [W-1:0] rsp_sum;
  logic         rsp_c, rsp_v, rsp_z;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rca8_share_ctrl #(.NBYTES(NBYTES)) dut (
    .clk       (clk),
    .rst       (rst),
    .r0_valid  (r0_valid),
    .r0_ready  (r0_ready),
    .r0_sub    (r0_sub),
    .r0_a      (r0_a),
    .r0_b      (r0_b),
    .r1_valid  (r1_valid),
    .r1_ready  (r1_ready),
    .r1_sub    (r1_sub),
    .r1_a      (r1_a),
    .r1_b      (r1_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_c     (rsp_c),
    .rsp_v     (rsp_v),
    .rsp_z     (rsp_z)
  );

  typedef struct {
    logic         id;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] sum;
    logic         c;
    logic         v;
    logic         z;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference arithmetic on plain integers: true unsigned and signed results.
  function automatic void model(input logic sub, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] s, output logic c, output logic v,
                                output logic z);
    longint ua, ub, sa, sb, ures, sres;
    ua = longint'(a);
    ub = longint'(b);
    sa = a[W-1] ? ua - (longint'(1) << W) : ua;
    sb = b[W-1] ? ub - (longint'(1) << W) : ub;
    if (sub) begin
      ures = ua - ub;
      sres = sa - sb;
      c    = (ua >= ub);
    end else begin
      ures = ua + ub;
      sres = sa + sb;
      c    = (ures >= (longint'(1) << W));
    end
    s = ures[W-1:0];
    v = (sres >= (longint'(1) << (W - 1))) || (sres < -(longint'(1) << (W - 1)));
    z = (s == '0);
  endfunction

  function automatic logic [W-1:0] rand_operand();
    case ($urandom_range(5, 0))
      0:       return '0;
      1:       return {1'b0, {(W-1){1'b1}}};
      2:       return {1'b1, {(W-1){1'b0}}};
      3:       return '1;
      default: return W'($urandom);
    endcase
  endfunction

  task automatic drive_port(input logic id, input logic sub, input logic [W-1:0] a,
                            input logic [W-1:0] b);
    if (id) begin
      r1_valid = 1'b1; r1_sub = sub; r1_a = a; r1_b = b;
    end else begin
      r0_valid = 1'b1; r0_sub = sub; r0_a = a; r0_b = b;
    end
  endtask

  // Single operation on one port with rsp_ready high; checks latency and result.
  task automatic run_op(input logic id, input logic sub, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] es, input logic ec,
                        input logic ev, input logic ez);
    int lat;
    drive_port(id, sub, a, b);
    #1;
    check("accept_ready", id ? r1_ready : r0_ready, 1'b1);
    check("other_ready",  id ? r0_ready : r1_ready, 1'b0);
    tick();
    r0_valid = 1'b0;
    r1_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      tick();
      lat++;
    end
    check("latency", lat, NBYTES + 1);
    check("rsp_id",  rsp_id, id);
    check("rsp_sum", rsp_sum, es);
    check("rsp_cvz", {rsp_c, rsp_v, rsp_z}, {ec, ev, ez});
    tick();
    check("rsp_cleared", rsp_valid, 1'b0);
  endtask

  vec_t tbl[6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] exp_s0, exp_s1, es;
    logic         ec, ev, ez;
    int           grants[$];
    int           nrsp, wait_n;

    tbl[0] = '{1'b0, 1'b0, 16'h00FF, 16'h0001, 16'h0100, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b0, 1'b1};
    tbl[3] = '{1'b0, 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1};
    tbl[5] = '{1'b1, 1'b1, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b0, 1'b0};

    // Reset state, with both requesters asserting valid during reset.
    rst = 1'b1; rsp_ready = 1'b1;
    r0_valid = 1'b1; r0_sub = 1'b0; r0_a = '0; r0_b = '0;
    r1_valid = 1'b1; r1_sub = 1'b0; r1_a = '0; r1_b = '0;
    tick();
    tick();
    check("rst_ready",     {r0_ready, r1_ready}, 2'b00);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_id",    rsp_id, 1'b0);
    check("rst_rsp_sum",   rsp_sum, '0);
    check("rst_flags",     {rsp_c, rsp_v, rsp_z}, 3'b000);
    r0_valid = 1'b0;
    r1_valid = 1'b0;
    rst = 1'b0;
    tick();

    // Directed vectors.
    for (int i = 0; i < 6; i++)
      run_op(tbl[i].id, tbl[i].sub, tbl[i].a, tbl[i].b, tbl[i].sum, tbl[i].c, tbl[i].v, tbl[i].z);

    // Both requesters valid from reset: grants must alternate 0,1,0,1.
    rst = 1'b1;
    drive_port(1'b0, 1'b0, 16'h1111, 16'h2222);
    drive_port(1'b1, 1'b1, 16'h0500, 16'h0600);
    exp_s0 = 16'h3333;
    exp_s1 = 16'hFF00;
    tick();
    tick();
    rst = 1'b0;
    #1;
    nrsp = 0;
    for (int i = 0; i < 16; i++) begin
      check("alt_one_ready", r0_ready & r1_ready, 1'b0);
      if (r0_ready) grants.push_back(0);
      if (r1_ready) grants.push_back(1);
      if (rsp_valid) begin
        check("alt_rsp_id",  rsp_id, nrsp % 2);
        check("alt_rsp_sum", rsp_sum, (nrsp % 2) ? exp_s1 : exp_s0);
        nrsp++;
      end
      tick();
    end
    r0_valid = 1'b0;
    r1_valid = 1'b0;
    check("alt_grant_count", grants.size(), 4);
    check("alt_rsp_count",   nrsp, 4);
    for (int i = 0; i < grants.size() && i < 4; i++)
      check("alt_grant_order", grants[i], i % 2);
    tick();
    check("alt_idle", rsp_valid, 1'b0);

    // Backpressure: DONE held 5 cycles, other requester waiting.
    rsp_ready = 1'b0;
    drive_port(1'b0, 1'b0, 16'h0102, 16'h0304);
    #1;
    check("bp_accept", r0_ready, 1'b1);
    tick();
    r0_valid = 1'b0;
    drive_port(1'b1, 1'b1, 16'h0010, 16'h0020);
    wait_n = 0;
    while (!rsp_valid && wait_n < 10) begin
      tick();
      wait_n++;
    end
    check("bp_reached_done", rsp_valid, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid_held", rsp_valid, 1'b1);
      check("bp_sum_stable", rsp_sum, 16'h0406);
      check("bp_id_stable",  rsp_id, 1'b0);
      check("bp_no_ready",   {r0_ready, r1_ready}, 2'b00);
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    check("bp_still_valid", rsp_valid, 1'b1);
    tick();
    #1;
    check("bp_next_ready", r1_ready, 1'b1);
    tick();
    r1_valid = 1'b0;
    wait_n = 0;
    while (!rsp_valid && wait_n < 10) begin
      tick();
      wait_n++;
    end
    check("bp_next_sum", rsp_sum, 16'hFFF0);
    check("bp_next_id",  rsp_id, 1'b1);
    tick();

    // Reset pulsed during RUN byte 0: operation dropped, next one correct.
    drive_port(1'b0, 1'b0, 16'h4000, 16'h4000);
    #1;
    check("rr_accept", r0_ready, 1'b1);
    tick();
    r0_valid = 1'b0;
    rst = 1'b1;
    tick();
    check("rr_no_valid", rsp_valid, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < NBYTES + 3; i++) begin
      check("rr_no_rsp", rsp_valid, 1'b0);
      tick();
    end
    run_op(1'b0, 1'b0, 16'h4000, 16'h4000, 16'h8000, 1'b0, 1'b1, 1'b0);

    // Randomized traffic against the reference model.
    begin
      logic         pend[2], psub[2];
      logic [W-1:0] pa[2], pb[2];
      logic         outst, lg, w, any;
      int           age;
      logic         eid, ecq, evq, ezq;
      logic [W-1:0] esq;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      pend[0] = 1'b0; pend[1] = 1'b0;
      psub[0] = 1'b0; psub[1] = 1'b0;
      pa[0] = '0; pa[1] = '0; pb[0] = '0; pb[1] = '0;
      outst = 1'b0; lg = 1'b1; age = 0;
      eid = 1'b0; esq = '0; ecq = 1'b0; evq = 1'b0; ezq = 1'b0;
      for (int cyc = 0; cyc < 600; cyc++) begin
        if (outst) age++;
        for (int p = 0; p < 2; p++) begin
          if (!pend[p] && $urandom_range(1, 0) == 1) begin
            pend[p] = 1'b1;
            psub[p] = 1'($urandom_range(1, 0));
            pa[p]   = rand_operand();
            pb[p]   = rand_operand();
          end
        end
        r0_valid = pend[0]; r0_sub = psub[0]; r0_a = pa[0]; r0_b = pb[0];
        r1_valid = pend[1]; r1_sub = psub[1]; r1_a = pa[1]; r1_b = pb[1];
        rsp_ready = ($urandom_range(3, 0) != 0);
        #1;
        check("rnd_rsp_valid", rsp_valid, outst && (age >= NBYTES + 1));
        if (!outst) begin
          any = pend[0] | pend[1];
          w   = (pend[0] && pend[1]) ? ~lg : (pend[0] ? 1'b0 : 1'b1);
          check("rnd_ready", {r1_ready, r0_ready},
                any ? (w ? 2'b10 : 2'b01) : 2'b00);
          if (any) begin
            model(psub[w], pa[w], pb[w], esq, ecq, evq, ezq);
            eid     = w;
            outst   = 1'b1;
            age     = 0;
            pend[w] = 1'b0;
            lg      = w;
          end
        end else begin
          check("rnd_busy_ready", {r1_ready, r0_ready}, 2'b00);
          if (rsp_valid && rsp_ready && age >= NBYTES + 1) begin
            check("rnd_id",  rsp_id, eid);
            check("rnd_sum", rsp_sum, esq);
            check("rnd_cvz", {rsp_c, rsp_v, rsp_z}, {ecq, evq, ezq});
            outst = 1'b0;
          end
        end
        @(posedge clk);
        #1;
      end
      r0_valid = 1'b0;
      r1_valid = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
